// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core definitions: fetch state encoding and fetch constants.
package chip8_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t REQ_HI  = 2'd0;
  localparam fetch_state_t REQ_LO  = 2'd1;
  localparam fetch_state_t WAIT_LO = 2'd2;
  localparam fetch_state_t HOLD    = 2'd3;

  localparam int unsigned CHIP8_RESET_PC    = 'h200;
  localparam int unsigned CHIP8_INSTR_BYTES = 2;

endpackage

// File: rtl/chip8_fetch_unit.sv
// CHIP-8 instruction fetch stage: owns the PC, fetches big-endian 2-byte instructions.
// Optional perf counter enabled by defining CHIP8_FETCH_PERF_EN.
module chip8_fetch_unit
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = CHIP8_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [2*DATA_W-1:0]   instr,
  output logic [ADDR_W-1:0]     instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  halt,
  output logic [ADDR_W-1:0]     pc,
  output logic [15:0]           perf_count
);

  fetch_state_t state;
  logic         rdata_fresh;

  always_comb begin
    mem_addr = pc;
    mem_re   = 1'b0;
    case (state)
      REQ_HI: mem_re = !halt;
      REQ_LO: begin
        mem_addr = pc + ADDR_W'(1);
        mem_re   = !halt;
      end
      default: ;
    endcase
  end

  assign instr_valid = (state == HOLD);

  // mem_rdata only carries a requested byte in the cycle after a strobed read;
  // capturing on that cycle even under halt keeps a halted fetch intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ_HI;
      pc          <= ADDR_W'(RESET_PC);
      instr       <= '0;
      instr_pc    <= '0;
      rdata_fresh <= 1'b0;
    end else begin
      rdata_fresh <= mem_re;
      if (redirect_valid) begin
        pc    <= redirect_pc;
        state <= REQ_HI;
      end else begin
        case (state)
          REQ_HI: begin
            if (!halt) state <= REQ_LO;
          end
          REQ_LO: begin
            if (rdata_fresh) instr[2*DATA_W-1 -: DATA_W] <= mem_rdata;
            if (!halt) state <= WAIT_LO;
          end
          WAIT_LO: begin
            if (rdata_fresh) instr[DATA_W-1:0] <= mem_rdata;
            if (!halt) begin
              instr_pc <= pc;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (!halt && instr_ready) begin
              pc    <= pc + ADDR_W'(CHIP8_INSTR_BYTES);
              state <= REQ_HI;
            end
          end
        endcase
      end
    end
  end

`ifdef CHIP8_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_count <= '0;
    end else if (instr_valid && instr_ready && !halt) begin
      perf_count <= perf_count + 16'd1;
    end
  end
`else
  assign perf_count = '0;
`endif

endmodule

// File: tb/tb_chip8_fetch_unit.sv
// Self-checking bench for chip8_fetch_unit: per-cycle vector table plus reset/latency sequences.
module tb_chip8_fetch_unit;

`ifdef CHIP8_FETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        halt;
  logic [11:0] pc;
  logic [15:0] perf_count;

  logic [7:0] mem [4096];

  int n_cmp = 0;
  int n_err = 0;

  chip8_fetch_unit #(.ADDR_W(12), .DATA_W(8), .RESET_PC('h200)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .pc(pc),
    .perf_count(perf_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [11:0] rpc;
    logic        hlt;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [11:0] e_ipc;
    logic [11:0] e_pc;
    logic        e_re;
    logic [11:0] e_addr;
    logic [15:0] e_perf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic rv, input logic [11:0] rpc, input logic hlt,
                     input logic ev, input logic [15:0] ei, input logic [11:0] eipc,
                     input logic [11:0] epc, input logic ere, input logic [11:0] eaddr,
                     input logic [15:0] eperf);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
    v.e_valid = ev; v.e_instr = ei; v.e_ipc = eipc; v.e_pc = epc;
    v.e_re = ere; v.e_addr = eaddr; v.e_perf = eperf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  function automatic logic [15:0] perf_exp(input logic [15:0] v);
    return PERF_ON ? v : 16'h0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    for (int unsigned i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem['h200] = 8'h12; mem['h201] = 8'h34; mem['h202] = 8'h56; mem['h203] = 8'h78;
    mem['h204] = 8'h99; mem['h205] = 8'h88; mem['h2FF] = 8'hEE;
    mem['h300] = 8'hAB; mem['h301] = 8'hCD; mem['hFFF] = 8'h9A;
    mem['h000] = 8'hBC; mem['h001] = 8'h11; mem['h002] = 8'h22;
    mem['h003] = 8'h33; mem['h004] = 8'h44;

    //   rdy rv  rpc     hlt  valid instr     ipc     pc      re  addr    perf
    add(1, 0, 12'h000, 0,  0, 16'h0000, 12'h000, 12'h200, 1, 12'h200, 0);
    add(1, 0, 12'h000, 0,  0, 16'h0000, 12'h000, 12'h200, 1, 12'h201, 0);
    add(1, 0, 12'h000, 0,  0, 16'h1200, 12'h000, 12'h200, 0, 12'h200, 0);
    add(1, 0, 12'h000, 0,  1, 16'h1234, 12'h200, 12'h200, 0, 12'h200, 0);
    add(0, 0, 12'h000, 0,  0, 16'h1234, 12'h200, 12'h202, 1, 12'h202, 1);
    add(0, 0, 12'h000, 0,  0, 16'h1234, 12'h200, 12'h202, 1, 12'h203, 1);
    add(0, 0, 12'h000, 0,  0, 16'h5634, 12'h200, 12'h202, 0, 12'h202, 1);
    for (int k = 0; k < 5; k++)
      add(0, 0, 12'h000, 0,  1, 16'h5678, 12'h202, 12'h202, 0, 12'h202, 1);
    add(1, 0, 12'h000, 0,  1, 16'h5678, 12'h202, 12'h202, 0, 12'h202, 1);
    add(0, 0, 12'h000, 0,  0, 16'h5678, 12'h202, 12'h204, 1, 12'h204, 2);
    add(0, 1, 12'h300, 0,  0, 16'h5678, 12'h202, 12'h204, 1, 12'h205, 2);
    add(0, 0, 12'h000, 0,  0, 16'h5678, 12'h202, 12'h300, 1, 12'h300, 2);
    add(0, 0, 12'h000, 0,  0, 16'h5678, 12'h202, 12'h300, 1, 12'h301, 2);
    add(0, 0, 12'h000, 0,  0, 16'hAB78, 12'h202, 12'h300, 0, 12'h300, 2);
    add(1, 1, 12'h2FF, 0,  1, 16'hABCD, 12'h300, 12'h300, 0, 12'h300, 2);
    add(0, 0, 12'h000, 0,  0, 16'hABCD, 12'h300, 12'h2FF, 1, 12'h2FF, 3);
    add(0, 0, 12'h000, 0,  0, 16'hABCD, 12'h300, 12'h2FF, 1, 12'h300, 3);
    add(0, 0, 12'h000, 0,  0, 16'hEECD, 12'h300, 12'h2FF, 0, 12'h2FF, 3);
    add(0, 1, 12'hFFF, 0,  1, 16'hEEAB, 12'h2FF, 12'h2FF, 0, 12'h2FF, 3);
    add(0, 0, 12'h000, 0,  0, 16'hEEAB, 12'h2FF, 12'hFFF, 1, 12'hFFF, 3);
    add(0, 0, 12'h000, 0,  0, 16'hEEAB, 12'h2FF, 12'hFFF, 1, 12'h000, 3);
    add(0, 0, 12'h000, 0,  0, 16'h9AAB, 12'h2FF, 12'hFFF, 0, 12'hFFF, 3);
    add(1, 0, 12'h000, 0,  1, 16'h9ABC, 12'hFFF, 12'hFFF, 0, 12'hFFF, 3);
    add(0, 0, 12'h000, 0,  0, 16'h9ABC, 12'hFFF, 12'h001, 1, 12'h001, 4);
    add(0, 0, 12'h000, 0,  0, 16'h9ABC, 12'hFFF, 12'h001, 1, 12'h002, 4);
    add(0, 0, 12'h000, 1,  0, 16'h11BC, 12'hFFF, 12'h001, 0, 12'h001, 4);
    for (int k = 0; k < 3; k++)
      add(0, 0, 12'h000, 1,  0, 16'h1122, 12'hFFF, 12'h001, 0, 12'h001, 4);
    add(0, 0, 12'h000, 0,  0, 16'h1122, 12'hFFF, 12'h001, 0, 12'h001, 4);
    add(1, 0, 12'h000, 1,  1, 16'h1122, 12'h001, 12'h001, 0, 12'h001, 4);
    add(1, 0, 12'h000, 0,  1, 16'h1122, 12'h001, 12'h001, 0, 12'h001, 4);
    add(0, 0, 12'h000, 1,  0, 16'h1122, 12'h001, 12'h003, 0, 12'h003, 5);
    add(0, 0, 12'h000, 0,  0, 16'h1122, 12'h001, 12'h003, 1, 12'h003, 5);
    add(0, 0, 12'h000, 0,  0, 16'h1122, 12'h001, 12'h003, 1, 12'h004, 5);
    add(0, 0, 12'h000, 0,  0, 16'h3322, 12'h001, 12'h003, 0, 12'h003, 5);
    add(0, 0, 12'h000, 0,  1, 16'h3344, 12'h003, 12'h003, 0, 12'h003, 5);

    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", -1, 16'(instr_valid), 16'h0);
    check("reset_pc", -1, 16'(pc), 16'h200);
    check("reset_instr", -1, instr, 16'h0000);
    check("reset_instr_pc", -1, 16'(instr_pc), 16'h000);
    check("reset_mem_re", -1, 16'(mem_re), 16'h1);
    check("reset_perf", -1, perf_count, 16'h0);

    foreach (vecs[i]) begin
      instr_ready    = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      halt           = vecs[i].hlt;
      #1;
      check("instr_valid", i, 16'(instr_valid), 16'(vecs[i].e_valid));
      check("instr", i, instr, vecs[i].e_instr);
      check("instr_pc", i, 16'(instr_pc), 16'(vecs[i].e_ipc));
      check("pc", i, 16'(pc), 16'(vecs[i].e_pc));
      check("mem_re", i, 16'(mem_re), 16'(vecs[i].e_re));
      check("mem_addr", i, 16'(mem_addr), 16'(vecs[i].e_addr));
      check("perf_count", i, perf_count, perf_exp(vecs[i].e_perf));
      @(negedge clk);
    end
    instr_ready = 1'b0; redirect_valid = 1'b0; halt = 1'b0;

    // Reset while holding a valid instruction with ready asserted: reset wins.
    rst = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b0;
    #1;
    check("hold_rst_valid", -2, 16'(instr_valid), 16'h0);
    check("hold_rst_pc", -2, 16'(pc), 16'h200);
    check("hold_rst_perf", -2, perf_count, 16'h0);
    check("hold_rst_instr", -2, instr, 16'h0000);
    check("hold_rst_mem_addr", -2, 16'(mem_addr), 16'h200);

    // Bounded wait for the first instruction after reset release.
    cyc = 0;
    while (!instr_valid && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("first_latency", -3, 16'(cyc), 16'd3);
    check("first_instr", -3, instr, 16'h1234);
    check("first_instr_pc", -3, 16'(instr_pc), 16'h200);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    check("accept_pc", -3, 16'(pc), 16'h202);
    check("accept_valid", -3, 16'(instr_valid), 16'h0);
    check("accept_perf", -3, perf_count, perf_exp(16'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
